avmm_sdram_rw_wrapper: RTL and testbench

AVMM_SDRAM_RW_WRAPPER -- requirements
Module: avmm_sdram_rw_wrapper

---
 rtl/avmm_sdram_pkg.sv | 16 +
 rtl/avmm_sdram_rw_wrapper_if.sv | 30 +++
 rtl/avmm_rd_beat_counter.sv | 54 +++++
 rtl/avmm_sdram_rw_wrapper.sv | 95 +++++++++
 tb/tb_avmm_sdram_rw_wrapper.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avmm_sdram_pkg.sv
// avmm_sdram_pkg: shared FSM state type and default widths for the SDRAM read/write wrapper.
package avmm_sdram_pkg;

    localparam int SDRAM_DATA_W_DEF = 128;
    localparam int ADDR_W_DEF       = 32;
    localparam int BURST_W_DEF      = 11;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_DATA,
        WR_DATA,
        DONE
    } state_e;

endpackage

// File: rtl/avmm_sdram_rw_wrapper_if.sv
// avmm_sdram_rw_wrapper_if: Avalon-MM burst bus between the wrapper (master) and the SDRAM controller (slave).
interface avmm_sdram_rw_wrapper_if
    import avmm_sdram_pkg::*;
#(
    parameter int DATA_W  = SDRAM_DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) ();

    logic [ADDR_W-1:0]   address;
    logic [BURST_W-1:0]  burstcount;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, burstcount, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, burstcount, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/avmm_rd_beat_counter.sv
// avmm_rd_beat_counter: counts returned read beats and forwards them, registered when AVMM_SDRAM_REG_RDATA_EN is defined.
module avmm_rd_beat_counter
    import avmm_sdram_pkg::*;
#(
    parameter int DATA_W  = SDRAM_DATA_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [BURST_W-1:0] cnt_i,
    input  logic               rdv_i,
    input  logic [DATA_W-1:0]  rdata_i,
    output logic               last_o,
    output logic               valid_o,
    output logic [DATA_W-1:0]  data_o
);

    logic [BURST_W-1:0] beat_q, beat_d;
    logic               beat;

    // beats arriving outside the data phase (e.g. stragglers after a reset) are dropped here
    assign beat   = en_i & rdv_i;
    assign beat_d = clr_i ? '0 : beat ? beat_q + 1'b1 : beat_q;
    assign last_o = beat & (beat_q == cnt_i - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) beat_q <= '0;
        else     beat_q <= beat_d;
    end

`ifdef AVMM_SDRAM_REG_RDATA_EN
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= beat;
            data_q  <= rdata_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
`else
    assign valid_o = beat;
    assign data_o  = rdata_i;
`endif

endmodule

// File: rtl/avmm_sdram_rw_wrapper.sv
// avmm_sdram_rw_wrapper: turns single read/write burst requests into Avalon-MM burst transactions.
// Define AVMM_SDRAM_REG_RDATA_EN to register read_valid/read_data one cycle after readdatavalid.
module avmm_sdram_rw_wrapper
    import avmm_sdram_pkg::*;
#(
    parameter int SDRAM_DATA_W = SDRAM_DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int BURST_W      = BURST_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       rw_addr,
    input  logic [BURST_W-1:0]      rw_cnt,
    output logic                    rw_done,
    input  logic                    read_start,
    output logic                    read_valid,
    output logic [SDRAM_DATA_W-1:0] read_data,
    input  logic                    write_start,
    output logic                    write_nxt,
    input  logic [SDRAM_DATA_W-1:0] write_data,
    avmm_sdram_rw_wrapper_if.master avm
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BURST_W-1:0] cnt_q, cnt_d, wbeat_q, wbeat_d;
    logic               done_q;
    logic               rd_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wbeat_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wbeat_q <= wbeat_d;
            done_q  <= state_q == DONE;
        end
    end

    // read has priority over write; a zero-length request skips the bus entirely
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wbeat_d = wbeat_q;
        case (state_q)
            IDLE: if (read_start | write_start) begin
                addr_d  = rw_addr;
                cnt_d   = rw_cnt;
                wbeat_d = '0;
                state_d = (rw_cnt == '0) ? DONE : read_start ? RD_CMD : WR_DATA;
            end
            RD_CMD:  state_d = avm.waitrequest ? RD_CMD : RD_DATA;
            RD_DATA: state_d = rd_last ? DONE : RD_DATA;
            WR_DATA: if (write_nxt) begin
                wbeat_d = wbeat_q + 1'b1;
                state_d = (wbeat_q == cnt_q - 1'b1) ? DONE : WR_DATA;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign avm.read       = state_q == RD_CMD;
    assign avm.write      = state_q == WR_DATA;
    assign avm.address    = addr_q;
    assign avm.burstcount = cnt_q;
    assign avm.writedata  = write_data;
    assign avm.byteenable = '1;
    assign write_nxt      = avm.write & ~avm.waitrequest;
    assign rw_done        = done_q;

    avmm_rd_beat_counter #(
        .DATA_W (SDRAM_DATA_W),
        .BURST_W(BURST_W)
    ) u_rd_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == IDLE),
        .en_i   (state_q == RD_DATA),
        .cnt_i  (cnt_q),
        .rdv_i  (avm.readdatavalid),
        .rdata_i(avm.readdata),
        .last_o (rd_last),
        .valid_o(read_valid),
        .data_o (read_data)
    );

endmodule

// File: tb/tb_avmm_sdram_rw_wrapper.sv
// tb_avmm_sdram_rw_wrapper: table-driven read/write bursts with a queue scoreboard, plus zero-length and reset corner cases.
module tb_avmm_sdram_rw_wrapper;

    logic         clk;
    logic         rst;
    logic [31:0]  rw_addr;
    logic [10:0]  rw_cnt;
    logic         rw_done;
    logic         read_start;
    logic         read_valid;
    logic [127:0] read_data;
    logic         write_start;
    logic         write_nxt;
    logic [127:0] write_data;

    avmm_sdram_rw_wrapper_if #(.DATA_W(128), .ADDR_W(32), .BURST_W(11)) avm ();

    avmm_sdram_rw_wrapper #(
        .SDRAM_DATA_W(128),
        .ADDR_W      (32),
        .BURST_W     (11)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rw_addr    (rw_addr),
        .rw_cnt     (rw_cnt),
        .rw_done    (rw_done),
        .read_start (read_start),
        .read_valid (read_valid),
        .read_data  (read_data),
        .write_start(write_start),
        .write_nxt  (write_nxt),
        .write_data (write_data),
        .avm        (avm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          both;
        logic [31:0] addr;
        logic [10:0] cnt;
        int          w;
        int          gap;
        logic [31:0] mask;
        int          exp_cmd;
        int          exp_wacc;
        int          exp_wcyc;
    } vec_t;

    vec_t         tbl [8];
    logic [127:0] rd_q [$];
    logic [127:0] wr_q [$];
    logic [31:0]  exp_addr;
    logic [10:0]  exp_cnt;
    logic [15:0]  be_ones;
    int           checks, errors;
    int           rd_cmd_n, wr_acc_n, wr_cyc_n, done_n;
    logic         s_done, s_wnxt, s_rvalid, s_read, s_write;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic logic [127:0] beat(input logic [31:0] a, input int i);
        return {a, 64'h0123_4567_89AB_CDEF, 16'hBEEF, i[15:0]};
    endfunction

    // sample outputs at the falling edge, then advance to just after the next rising edge
    task automatic tick();
        @(negedge clk);
        s_done   = rw_done;
        s_wnxt   = write_nxt;
        s_rvalid = read_valid;
        s_read   = avm.read;
        s_write  = avm.write;
        if (!rst) begin
            if (read_valid) begin
                if (rd_q.size() == 0) chk("rd_extra_beat", 1'b1, 1'b0);
                else chk("rd_data", read_data, rd_q.pop_front());
            end
            if (write_nxt) begin
                wr_acc_n++;
                if (wr_q.size() == 0) chk("wr_extra_beat", 1'b1, 1'b0);
                else chk("wr_data", avm.writedata, wr_q.pop_front());
                chk("wr_byteenable", avm.byteenable, be_ones);
            end
            if (avm.read) begin
                rd_cmd_n++;
                chk("rd_address", avm.address, exp_addr);
                chk("rd_burstcount", avm.burstcount, exp_cnt);
            end
            if (avm.write) begin
                wr_cyc_n++;
                chk("wr_address", avm.address, exp_addr);
                chk("wr_burstcount", avm.burstcount, exp_cnt);
            end
            if (rw_done) done_n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd_burst(input logic [31:0] addr, input logic [10:0] cnt, input int w, input int gap,
                            input logic [127:0] base, input bit both);
        exp_addr = addr;
        exp_cnt  = cnt;
        for (int i = 0; i < int'(cnt); i++) rd_q.push_back(base + 128'(i));
        rw_addr     = addr;
        rw_cnt      = cnt;
        read_start  = 1'b1;
        write_start = both;
        s_done      = 1'b0;
        tick();
        read_start  = 1'b0;
        write_start = 1'b0;
        if (cnt != 0) begin
            avm.waitrequest = w > 0;
            for (int i = 0; i < w; i++) begin
                tick();
                avm.waitrequest = (i + 1) < w;
            end
            tick();
            for (int i = 0; i < int'(cnt); i++) begin
                repeat (gap) tick();
                avm.readdatavalid = 1'b1;
                avm.readdata      = base + 128'(i);
                tick();
                avm.readdatavalid = 1'b0;
            end
        end
        for (int k = 0; k < 20 && !s_done; k++) tick();
    endtask

    task automatic wr_burst(input logic [31:0] addr, input logic [10:0] cnt, input logic [31:0] mask);
        int idx;
        idx      = 0;
        exp_addr = addr;
        exp_cnt  = cnt;
        for (int i = 0; i < int'(cnt); i++) wr_q.push_back(beat(addr, i));
        rw_addr     = addr;
        rw_cnt      = cnt;
        write_data  = beat(addr, 0);
        write_start = 1'b1;
        s_done      = 1'b0;
        tick();
        write_start = 1'b0;
        for (int k = 0; k < 64 && !s_done; k++) begin
            avm.waitrequest = (k < 32) ? mask[k] : 1'b0;
            tick();
            if (s_wnxt) begin
                idx++;
                write_data = beat(addr, idx);
            end
        end
        avm.waitrequest = 1'b0;
    endtask

    initial begin
        int d0, c0, a0, y0;
        checks = 0;
        errors = 0;
        rd_cmd_n = 0;
        wr_acc_n = 0;
        wr_cyc_n = 0;
        done_n   = 0;
        be_ones  = '1;
        exp_addr = '0;
        exp_cnt  = '0;
        // wr both addr cnt w gap mask cmd wacc wcyc
        tbl[0] = '{1'b0, 1'b0, 32'h2000_0000, 11'd4, 2, 1, 32'h0,  3, 0, 0};
        tbl[1] = '{1'b1, 1'b0, 32'h2000_0100, 11'd3, 0, 0, 32'h5,  0, 3, 5};
        tbl[2] = '{1'b0, 1'b0, 32'h2000_0200, 11'd1, 0, 0, 32'h0,  1, 0, 0};
        tbl[3] = '{1'b1, 1'b0, 32'h2000_0300, 11'd5, 0, 0, 32'hB,  0, 5, 8};
        tbl[4] = '{1'b0, 1'b0, 32'h2000_0400, 11'd0, 0, 0, 32'h0,  0, 0, 0};
        tbl[5] = '{1'b1, 1'b0, 32'h2000_0500, 11'd0, 0, 0, 32'h0,  0, 0, 0};
        tbl[6] = '{1'b0, 1'b1, 32'h2000_0600, 11'd2, 1, 0, 32'h0,  2, 0, 0};
        tbl[7] = '{1'b0, 1'b0, 32'h2000_0700, 11'd7, 0, 0, 32'h0,  1, 0, 0};

        rst = 1'b1;
        read_start = 1'b0;
        write_start = 1'b0;
        rw_addr = '0;
        rw_cnt = '0;
        write_data = '0;
        avm.waitrequest = 1'b0;
        avm.readdata = '0;
        avm.readdatavalid = 1'b0;
        repeat (3) tick();
        chk("rst_read", avm.read, 1'b0);
        chk("rst_write", avm.write, 1'b0);
        chk("rst_rw_done", rw_done, 1'b0);
        chk("rst_read_valid", read_valid, 1'b0);
        chk("rst_write_nxt", write_nxt, 1'b0);
        chk("rst_address", avm.address, 32'h0);
        chk("rst_burstcount", avm.burstcount, 11'h0);
        rst = 1'b0;
        tick();

        // consecutive entries start in the cycle right after the previous rw_done
        for (int t = 0; t < 8; t++) begin
            d0 = done_n;
            c0 = rd_cmd_n;
            a0 = wr_acc_n;
            y0 = wr_cyc_n;
            if (tbl[t].wr) wr_burst(tbl[t].addr, tbl[t].cnt, tbl[t].mask);
            else rd_burst(tbl[t].addr, tbl[t].cnt, tbl[t].w, tbl[t].gap, 128'hA0 + 128'(t * 16), tbl[t].both);
            chk($sformatf("v%0d_done", t), 128'(done_n - d0), 128'(1));
            chk($sformatf("v%0d_cmd_cycles", t), 128'(rd_cmd_n - c0), 128'(tbl[t].exp_cmd));
            chk($sformatf("v%0d_wr_accepts", t), 128'(wr_acc_n - a0), 128'(tbl[t].exp_wacc));
            chk($sformatf("v%0d_wr_cycles", t), 128'(wr_cyc_n - y0), 128'(tbl[t].exp_wcyc));
            chk($sformatf("v%0d_rd_left", t), 128'(rd_q.size()), 128'(0));
            chk($sformatf("v%0d_wr_left", t), 128'(wr_q.size()), 128'(0));
        end

        // zero-length read: no command, rw_done exactly two cycles after start
        rw_cnt = '0;
        rw_addr = 32'h2000_0800;
        exp_addr = rw_addr;
        exp_cnt = '0;
        read_start = 1'b1;
        tick();
        chk("z_c0_done", s_done, 1'b0);
        read_start = 1'b0;
        tick();
        chk("z_c1_done", s_done, 1'b0);
        chk("z_c1_read", s_read, 1'b0);
        tick();
        chk("z_c2_done", s_done, 1'b1);
        chk("z_c2_read", s_read, 1'b0);
        tick();
        chk("z_c3_done", s_done, 1'b0);

        // reset in the middle of a write burst
        exp_addr = 32'h2000_0900;
        exp_cnt = 11'd4;
        for (int i = 0; i < 4; i++) wr_q.push_back(beat(exp_addr, i));
        rw_addr = exp_addr;
        rw_cnt = exp_cnt;
        write_data = beat(exp_addr, 0);
        write_start = 1'b1;
        tick();
        write_start = 1'b0;
        tick();
        write_data = beat(exp_addr, 1);
        tick();
        write_data = beat(exp_addr, 2);
        chk("abort_write_active", s_write, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_write_low", avm.write, 1'b0);
        chk("abort_address", avm.address, 32'h0);
        chk("abort_burstcount", avm.burstcount, 11'h0);
        wr_q.delete();
        d0 = done_n;
        avm.readdatavalid = 1'b1;
        avm.readdata = 128'hDEAD;
        tick();
        avm.readdatavalid = 1'b0;
        chk("stray_rdv_ignored", s_rvalid, 1'b0);
        repeat (3) tick();
        chk("abort_no_done", 128'(done_n - d0), 128'(0));
        c0 = rd_cmd_n;
        rd_burst(32'h2000_0A00, 11'd2, 1, 0, 128'hC0, 1'b0);
        chk("post_rst_done", 128'(done_n - d0), 128'(1));
        chk("post_rst_cmd", 128'(rd_cmd_n - c0), 128'(2));
        chk("post_rst_rd_left", 128'(rd_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
